module_reg_seq: RTL and testbench
=================================

# module_reg_seq

Command sequencer that drives the write-side control of the processor's register bank: it turns single-transaction commands into the one-cycle Wen, INC and register-clear strobes and the BusOut value that each register consumes. It reads back every register's dout and z flag, so it can perform register-to-register moves and report the zero status after each command. It sits between the control unit's command stream and the bank of Module_RegF instances. It is the initiator for which each register is the responder.

## Interface
Parameters:
- NREG, 6, number of registers driven (1..8); register indices are 3 bits wide.
- W, 8, register and bus width.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 LDI, 2 MOV, 3 INC, 4 CLR, 5 INCN; 6 and 7 are illegal.
- cmd_dst  in  3  destination register index.
- cmd_src  in  3  source register index (MOV only).
- cmd_imm  in  W  immediate value (LDI) or repeat count (INCN).
- BusOut  out  W  bus value presented to the registers.
- Wen  out  NREG  one-hot write strobe.
- INC  out  NREG  one-hot increment strobe.
- RegRST  out  NREG  one-hot clear strobe to the register's RST input.
- dout_all  in  NREG*W  concatenated register outputs; register i occupies bits [i*W +: W].
- z  in  NREG  register zero flags.
- done  out  1  one-cycle completion pulse.
- rsp_z  out  1  z[dst] sampled in the done cycle.
- err  out  1  valid with done; flags an illegal or out-of-range command.

## Operation
- The state machine has five states: IDLE, READ, STROBE, REPEAT and DONE.
- cmd_ready is 1 only in IDLE.
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1. On acceptance the sequencer latches op, dst, src and imm.
- Routing from IDLE on acceptance:
  - LDI, INC and CLR go to STROBE.
  - MOV goes to READ.
  - INCN goes to REPEAT, or to DONE if imm is 0.
  - NOP goes to DONE.
- READ latches dout_all[src] into bus_q, then goes to STROBE.
- STROBE lasts exactly one cycle, then goes to DONE. Its output depends on the opcode:
  - LDI: Wen[dst]=1, BusOut=imm.
  - MOV: Wen[dst]=1, BusOut=bus_q.
  - INC: INC[dst]=1.
  - CLR: RegRST[dst]=1.
- REPEAT holds INC[dst]=1 for exactly imm consecutive cycles using a W-bit down-counter, then goes to DONE.
- DONE lasts one cycle with done=1 and rsp_z=z[dst]. The next state is IDLE.
- Error conditions:
  - An illegal opcode, dst ≥ NREG, or (MOV only) src ≥ NREG goes directly to DONE with err=1.
  - In that case no strobe is issued and rsp_z=0.
- Output rules:
  - Every strobe output is registered and at most one bit across Wen, INC and RegRST is set in any cycle.
  - BusOut is 0 in every cycle where Wen is 0.
- MOV with src==dst is legal; the register rewrites its own value.
- cmd_valid while cmd_ready=0 is ignored. The command fields need not be held stable after acceptance.

## Timing
- Reset values, applied immediately on RST=0:
  - state IDLE, so cmd_ready=1.
  - BusOut=0, Wen=INC=RegRST=0.
  - done=0, rsp_z=0, err=0.
  - bus_q=0 and counter=0.
- Latency from the acceptance edge to the done cycle:
  - NOP and illegal commands: 1 cycle.
  - LDI, INC and CLR: 2 cycles.
  - MOV: 3 cycles.
  - INCN: imm+1 cycles.
- Next acceptance can occur no earlier than the edge that ends the done cycle.
- rsp_z reflects the register's value after the strobe, because the register updates at the edge that ends the strobe cycle.
- INC applied to a register holding 2^W−1 wraps per the register's own behaviour; the sequencer does not check for wrap.
- RST asserted mid-command takes effect immediately: strobes drop in the same cycle, no done is issued, and the partial INCN count is lost.

## Configuration
- REGSEQ_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 while in REPEAT stops INC in that same cycle and moves to DONE with err=1.
  - abort is ignored in every other state.
- REGSEQ_ABORT_EN undefined: the abort port does not exist and REPEAT always runs to completion.

## Test plan
- Reset release: every output equals its listed reset value; first LDI dst=2 imm=8'h3C → Wen=6'b000100 and BusOut=8'h3C for one cycle, then done=1, rsp_z=0, err=0.
- MOV src=2 dst=0 with register 2 holding 8'h3C → READ cycle, then Wen[0]=1 with BusOut=8'h3C, done at edge+3.
- INCN dst=1 imm=5 → INC[1] high for exactly 5 cycles, done at edge+6. INCN imm=0 → no INC, done at edge+1.
- CLR dst=3 → RegRST[3] for one cycle, then done with rsp_z=1 (register 3 assumed to have a clear value of 0).
- Error cases: dst=7 with NREG=6, and op=6 → no strobes, done with err=1 at edge+1. cmd_valid held during busy → no second acceptance until IDLE.
- Reset mid-operation: RST pulled low on the 3rd cycle of INCN imm=10 → INC drops immediately and no done pulse. With REGSEQ_ABORT_EN, abort on the 4th REPEAT cycle → 3 INC pulses total, then done with err=1.

Source files
------------

// File: rtl/module_reg_seq_if.sv
// Command and register-bank bundle between the control unit, module_reg_seq and the Module_RegF bank.
// master = sequencer side; slave = the control unit / register bank side.
`timescale 1ns/1ps
interface module_reg_seq_if #(
  parameter int NREG = 6,
  parameter int W    = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic [2:0]          cmd_dst;
  logic [2:0]          cmd_src;
  logic [W-1:0]        cmd_imm;
  logic [W-1:0]        BusOut;
  logic [NREG-1:0]     Wen;
  logic [NREG-1:0]     INC;
  logic [NREG-1:0]     RegRST;
  logic [NREG*W-1:0]   dout_all;
  logic [NREG-1:0]     z;
  logic                done;
  logic                rsp_z;
  logic                err;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, dout_all, z,
    output cmd_ready, BusOut, Wen, INC, RegRST, done, rsp_z, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, dout_all, z,
    input  cmd_ready, BusOut, Wen, INC, RegRST, done, rsp_z, err
  );
endinterface

// File: rtl/module_reg_seq.sv
// Register-bank command sequencer: turns commands into one-cycle Wen/INC/RegRST strobes plus BusOut.
// Optional macro REGSEQ_ABORT_EN adds an abort input that ends an INCN repeat early with err.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | cmd_ready=1, waiting for a command
// S_READ   | MOV: capture source register onto the bus register
// S_STROBE | single Wen/INC/RegRST strobe cycle
// S_REPEAT | INCN: INC[dst] held while the down-counter runs out
// S_DONE   | done pulse, rsp_z/err reported
`timescale 1ns/1ps
module module_reg_seq #(
  parameter int NREG = 6,
  parameter int W    = 8
) (
  input  logic Clk,
  input  logic RST,
`ifdef REGSEQ_ABORT_EN
  input  logic abort,
`endif
  module_reg_seq_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_STROBE, S_REPEAT, S_DONE} state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_INCN = 3'd5;

  state_t          state_q, state_d;
  logic [2:0]      dst_q, dst_d, src_q, src_d;
  logic [W-1:0]    bus_q, bus_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [NREG-1:0] wen_q, wen_d, inc_q, inc_d, rrst_q, rrst_d;
  logic            done_q, done_d, err_q, err_d;
  logic            abort_hit;
  logic            cmd_bad;

`ifdef REGSEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    onehot = '0;
    for (int i = 0; i < NREG; i++)
      if (idx == 3'(i)) onehot[i] = 1'b1;
  endfunction

  function automatic logic in_rng(input logic [2:0] idx);
    in_rng = ({1'b0, idx} < 4'(NREG));
  endfunction

  function automatic logic [W-1:0] pick_reg(input logic [NREG*W-1:0] v, input logic [2:0] idx);
    pick_reg = '0;
    for (int i = 0; i < NREG; i++)
      if (idx == 3'(i)) pick_reg = v[i*W +: W];
  endfunction

  assign cmd_bad = (bus.cmd_op > OP_INCN) || !in_rng(bus.cmd_dst) ||
                   ((bus.cmd_op == OP_MOV) && !in_rng(bus.cmd_src));

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    src_d   = src_q;
    bus_d   = '0;
    cnt_d   = cnt_q;
    wen_d   = '0;
    inc_d   = '0;
    rrst_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          dst_d = bus.cmd_dst;
          src_d = bus.cmd_src;
          if (cmd_bad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            case (bus.cmd_op)
              OP_LDI: begin
                state_d = S_STROBE;
                wen_d   = onehot(bus.cmd_dst);
                bus_d   = bus.cmd_imm;
              end
              OP_MOV: state_d = S_READ;
              OP_INC: begin
                state_d = S_STROBE;
                inc_d   = onehot(bus.cmd_dst);
              end
              OP_CLR: begin
                state_d = S_STROBE;
                rrst_d  = onehot(bus.cmd_dst);
              end
              OP_INCN: begin
                if (bus.cmd_imm == '0) begin
                  state_d = S_DONE;
                end else begin
                  state_d = S_REPEAT;
                  cnt_d   = bus.cmd_imm - W'(1);
                  inc_d   = onehot(bus.cmd_dst);
                end
              end
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      S_READ: begin
        state_d = S_STROBE;
        bus_d   = pick_reg(bus.dout_all, src_q);
        wen_d   = onehot(dst_q);
      end
      S_STROBE: state_d = S_DONE;
      S_REPEAT: begin
        // counter holds the INC cycles still owed after the current one
        if (abort_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - W'(1);
          inc_d = onehot(dst_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      dst_q   <= '0;
      src_q   <= '0;
      bus_q   <= '0;
      cnt_q   <= '0;
      wen_q   <= '0;
      inc_q   <= '0;
      rrst_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      inc_q   <= inc_d;
      rrst_q  <= rrst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.BusOut    = bus_q;
  assign bus.Wen       = wen_q;
  // abort must cut INC within the cycle it is raised, so it gates the registered strobe
  assign bus.INC       = inc_q & ~{NREG{abort_hit && (state_q == S_REPEAT)}};
  assign bus.RegRST    = rrst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  // z is sampled live: the register has absorbed the strobe by the done cycle
  assign bus.rsp_z     = done_q && !err_q && |(bus.z & onehot(dst_q));

endmodule

// File: tb/tb_module_reg_seq.sv
// Randomized bench for module_reg_seq: register bank model, per-command expected output trace, per-cycle compare.
// Builds with or without REGSEQ_ABORT_EN.
`timescale 1ns/1ps
module tb_module_reg_seq;
  localparam int NREG = 6;
  localparam int W    = 8;
  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, INC = 3'd3, CLR = 3'd4, INCN = 3'd5;

  typedef struct {
    logic [NREG-1:0] wen, inc, rrst;
    logic [W-1:0]    bus;
    logic            done, err, rspz, ready;
  } exp_t;

  logic Clk = 1'b0;
  logic RST = 1'b0;
  logic bank_clr = 1'b1;
`ifdef REGSEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  always #5 Clk = ~Clk;

  module_reg_seq_if #(.NREG(NREG), .W(W)) bus ();

  module_reg_seq #(.NREG(NREG), .W(W)) dut (
    .Clk(Clk),
    .RST(RST),
`ifdef REGSEQ_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );

  int vectors = 0, miscompares = 0, cyc = 0;
  int done_cyc = 0, inc_pulses = 0, last_lat = 0;
  logic exp_ready = 1'b1;
  logic [NREG-1:0] last_wen = '0;
  logic [W-1:0]    last_bus = '0;
  logic            last_err = 1'b0;
  logic [W-1:0]    bank  [NREG];
  logic [W-1:0]    mregs [8];
  exp_t q[$];

  // register bank (Module_RegF behaviour), driven only by the DUT strobes
  always @(posedge Clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bank_clr || bus.RegRST[i]) bank[i] <= '0;
      else if (bus.Wen[i])           bank[i] <= bus.BusOut;
      else if (bus.INC[i])           bank[i] <= bank[i] + 1'b1;
    end
  end

  always_comb begin
    bus.dout_all = '0;
    bus.z        = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.dout_all[i*W +: W] = bank[i];
      bus.z[i]               = (bank[i] == '0);
    end
  end

  always @(posedge Clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, expv);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    e.wen = '0; e.inc = '0; e.rrst = '0; e.bus = '0;
    e.done = 1'b0; e.err = 1'b0; e.rspz = 1'b0; e.ready = 1'b0;
    return e;
  endfunction

  function automatic logic [NREG-1:0] oh(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e = mk();
      e.ready = 1'b1;
    end
    exp_ready = e.ready;
    chk("wen",       bus.Wen,       e.wen);
    chk("inc",       bus.INC,       e.inc);
    chk("regrst",    bus.RegRST,    e.rrst);
    chk("busout",    bus.BusOut,    e.bus);
    chk("done",      bus.done,      e.done);
    chk("err",       bus.err,       e.err);
    chk("rsp_z",     bus.rsp_z,     e.rspz);
    chk("cmd_ready", bus.cmd_ready, e.ready);
    if (bus.INC != '0) inc_pulses++;
    if (bus.Wen != '0) begin
      last_wen = bus.Wen;
      last_bus = bus.BusOut;
    end
    if (bus.done) begin
      done_cyc = cyc;
      last_err = bus.err;
    end
  end

  task automatic junk();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 3'($urandom);
    bus.cmd_dst   = 3'($urandom);
    bus.cmd_src   = 3'($urandom);
    bus.cmd_imm   = W'($urandom);
  endtask

  // abort_at / rst_at: cycle after acceptance (1 = first) in which to raise abort / pull RST low; 0 = never
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [W-1:0] imm, input int abort_at, input int rst_at);
    exp_t seq[$];
    exp_t e;
    int n, acc, k;
    logic bad;
    logic [W-1:0] old;
    bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_src = src; bus.cmd_imm = imm;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(posedge Clk);
      n++;
    end while (!exp_ready && n < 64);
    if (!exp_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    #1;
    acc = cyc;
    inc_pulses = 0;
    bad = (op > INCN) || (dst >= NREG) || (op == MOV && src >= NREG);
    old = mregs[dst];
    e = mk();
    if (bad) begin
      e.done = 1; e.err = 1; seq.push_back(e);
    end else begin
      case (op)
        LDI: begin
          e.wen = oh(dst); e.bus = imm; seq.push_back(e);
          mregs[dst] = imm;
        end
        MOV: begin
          seq.push_back(e);
          e.wen = oh(dst); e.bus = mregs[src]; seq.push_back(e);
          mregs[dst] = mregs[src];
        end
        INC: begin
          e.inc = oh(dst); seq.push_back(e);
          mregs[dst] = mregs[dst] + 1'b1;
        end
        CLR: begin
          e.rrst = oh(dst); seq.push_back(e);
          mregs[dst] = '0;
        end
        INCN: begin
          k = (abort_at > 0 && abort_at <= int'(imm)) ? abort_at - 1 : int'(imm);
          e.inc = oh(dst);
          for (int i = 0; i < k; i++) seq.push_back(e);
          mregs[dst] = mregs[dst] + W'(k);
          if (k != int'(imm)) begin
            seq.push_back(mk());
            bad = 1'b1;
          end
        end
        default: ;
      endcase
      e = mk();
      e.done = 1; e.err = bad; e.rspz = !bad && (mregs[dst] == '0);
      seq.push_back(e);
    end
    foreach (seq[i]) q.push_back(seq[i]);
    for (int c = 1; c <= seq.size(); c++) begin
      if (c > 1) begin
        @(posedge Clk);
        #1;
      end
      junk();
`ifdef REGSEQ_ABORT_EN
      abort = (c == abort_at) || (op != INCN && $urandom_range(0, 3) == 0);
`endif
      if (c == rst_at) begin
        RST = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        chk("rst_inc_drop", bus.INC, '0);
        chk("rst_done_low", bus.done, 0);
        q.delete();
        mregs[dst] = old + W'(rst_at - 1);
        @(posedge Clk);
        #1;
        RST = 1'b1;
        last_lat = -1;
        return;
      end
    end
    @(negedge Clk);
    #1;
`ifdef REGSEQ_ABORT_EN
    abort = 1'b0;
`endif
    bus.cmd_valid = 1'b0;
    last_lat = done_cyc - acc + 1;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_src = '0; bus.cmd_imm = '0;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    repeat (3) @(posedge Clk);
    #1;
    RST = 1'b1;
    bank_clr = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    issue(LDI, 3'd2, 3'd0, 8'h3C, 0, 0);
    chk("ldi_wen", last_wen, 6'b000100);
    chk("ldi_bus", last_bus, 8'h3C);
    chk("ldi_lat", last_lat, 2);
    chk("ldi_bank2", bank[2], 8'h3C);

    issue(MOV, 3'd0, 3'd2, 8'h00, 0, 0);
    chk("mov_wen", last_wen, 6'b000001);
    chk("mov_bus", last_bus, 8'h3C);
    chk("mov_lat", last_lat, 3);
    chk("mov_bank0", bank[0], 8'h3C);

    issue(LDI, 3'd1, 3'd0, 8'hFE, 0, 0);
    issue(INCN, 3'd1, 3'd0, 8'd5, 0, 0);
    chk("incn5_pulses", inc_pulses, 5);
    chk("incn5_lat", last_lat, 6);
    chk("incn5_wrap", bank[1], 8'h03);

    issue(INCN, 3'd1, 3'd0, 8'd0, 0, 0);
    chk("incn0_pulses", inc_pulses, 0);
    chk("incn0_lat", last_lat, 1);

    issue(LDI, 3'd3, 3'd0, 8'h55, 0, 0);
    issue(CLR, 3'd3, 3'd0, 8'h00, 0, 0);
    chk("clr_lat", last_lat, 2);
    chk("clr_bank3", bank[3], 8'h00);

    issue(LDI, 3'd7, 3'd0, 8'h11, 0, 0);
    chk("dst7_err", last_err, 1);
    chk("dst7_lat", last_lat, 1);
    issue(3'd6, 3'd0, 3'd0, 8'h11, 0, 0);
    chk("op6_err", last_err, 1);
    chk("op6_lat", last_lat, 1);

    issue(INCN, 3'd1, 3'd0, 8'd10, 0, 3);
    chk("rst_bank1", bank[1], 8'h05);
    repeat (3) @(posedge Clk);
    #1;

`ifdef REGSEQ_ABORT_EN
    issue(INCN, 3'd4, 3'd0, 8'd10, 4, 0);
    chk("abort_pulses", inc_pulses, 3);
    chk("abort_err", last_err, 1);
    chk("abort_lat", last_lat, 5);
`endif

    for (int n = 0; n < 200; n++) begin
      int r, ab;
      logic [2:0] op, d, s;
      logic [W-1:0] im;
      r = $urandom_range(0, 15);
      case (r)
        0:                 op = NOP;
        1, 2, 3, 14, 15:   op = LDI;
        4, 5:              op = MOV;
        6, 7:              op = INC;
        8:                 op = CLR;
        9, 10, 11:         op = INCN;
        12:                op = 3'd6;
        default:           op = 3'd7;
      endcase
      d  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(NREG, 7)) : 3'($urandom_range(0, NREG - 1));
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(NREG, 7)) : 3'($urandom_range(0, NREG - 1));
      im = (r == 14) ? '0 : (r == 15) ? '1 : W'($urandom);
      if (op == INCN) im = W'($urandom_range(0, 9));
      ab = 0;
`ifdef REGSEQ_ABORT_EN
      if (op == INCN && im != '0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, int'(im));
`endif
      issue(op, d, s, im, ab, 0);
    end

    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < NREG; i++) chk("bank_final", bank[i], mregs[i]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
